// File: rtl/seg_display_arbiter.sv
// Purpose: shares one 4-digit active-low seven-segment display between N_REQ
//          requesters using round-robin ownership with a minimum hold time.
// Latency: seg/an are registered; each update lands on the digit_tick edge.
//          Grant changes only at frame boundaries.
// Backpressure: none. req is level-sensitive and is sampled only at frame_end.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester display request (level)
//   pattern     : requester k frame in [32k+31:32k]; byte 3 = leftmost digit
//   dim         : (only when SEG_DIM_EN is defined) 25% duty digit enable
//   grant       : one-hot current owner, zero when idle
//   seg, an     : active-low segment / digit drive (dp in seg[7])
//   frame_tick  : one-cycle pulse at each frame boundary
// Optional feature macro: SEG_DIM_EN
module seg_display_arbiter #(
  parameter int N_REQ       = 3,
  parameter int SCAN_DIV    = 100_000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  pattern,
`ifdef SEG_DIM_EN
  input  logic                 dim,
`endif
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           seg,
  output logic [3:0]           an,
  output logic                 frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);
  localparam logic [OW-1:0] LAST_RST = OW'(N_REQ - 1);

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [OW-1:0]     r_owner, w_owner_nxt;
  logic [OW-1:0]     r_last, w_last_nxt;
  logic [HW-1:0]     r_held, w_held_nxt;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_pos, w_pos_nxt;
  logic [7:0]        r_seg, w_seg_nxt;
  logic [3:0]        r_an, w_an_nxt;
  logic              r_frame_tick;
  logic              w_digit_tick, w_frame_end;
  logic [N_REQ-1:0]  w_own_mask, w_others;
  logic [OW:0]       w_pick_idle, w_pick_own;
  logic [31:0]       w_frame;

  // Returns {found, index}: first set bit of mask searching upward from
  // start with wrap-around. Iterating from the far end lets the nearest
  // candidate overwrite the result last.
  function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] mask,
                                          input int start);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (mask[OW'(idx)]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  assign w_digit_tick = (r_cnt == CNT_MAX);
  assign w_frame_end  = w_digit_tick && (r_pos == 2'd3);
  assign w_pos_nxt    = r_pos + 2'd1;

  assign w_own_mask  = N_REQ'(1) << r_owner;
  assign w_others    = req & ~w_own_mask;
  assign w_pick_idle = rr_pick(req, (int'(r_last) + 1) % N_REQ);
  assign w_pick_own  = rr_pick(w_others, (int'(r_owner) + 1) % N_REQ);

  // Ownership FSM: decisions are taken only on the frame_end edge.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_held_nxt  = r_held;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_idle[OW]) begin
            w_state_nxt = S_OWN;
            w_owner_nxt = w_pick_idle[OW-1:0];
            w_held_nxt  = '0;
          end
        end
        S_OWN: begin
          if ((req & w_own_mask) == '0) begin
            // Owner let go: hand over or fall back to idle.
            w_last_nxt = r_owner;
            w_held_nxt = '0;
            if (w_pick_own[OW]) begin
              w_owner_nxt = w_pick_own[OW-1:0];
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (w_pick_own[OW] && (r_held >= HOLD_MAX)) begin
            // Hold time served and someone else is waiting.
            w_last_nxt  = r_owner;
            w_owner_nxt = w_pick_own[OW-1:0];
            w_held_nxt  = '0;
          end else if (r_held < HOLD_MAX) begin
            w_held_nxt = r_held + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Slot contents for the pos value about to be shown. Uses the next owner so
  // that the first digit of a new frame already belongs to the new owner.
  always_comb begin
    w_frame = '1;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_owner_nxt == OW'(k)) w_frame = pattern[32*k +: 32];
    end
    w_seg_nxt = 8'hFF;
    w_an_nxt  = 4'b1111;
    if (w_state_nxt == S_OWN) begin
      case (w_pos_nxt)
        2'd0: begin w_an_nxt = 4'b0111; w_seg_nxt = w_frame[31:24]; end
        2'd1: begin w_an_nxt = 4'b1011; w_seg_nxt = w_frame[23:16]; end
        2'd2: begin w_an_nxt = 4'b1101; w_seg_nxt = w_frame[15:8];  end
        default: begin w_an_nxt = 4'b1110; w_seg_nxt = w_frame[7:0]; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= LAST_RST;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_held  <= w_held_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_pos        <= 2'd0;
      r_seg        <= 8'hFF;
      r_an         <= 4'b1111;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_digit_tick) begin
        r_cnt <= '0;
        r_pos <= w_pos_nxt;
        r_seg <= w_seg_nxt;
        r_an  <= w_an_nxt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign grant      = (r_state == S_OWN) ? w_own_mask : '0;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

`ifdef SEG_DIM_EN
  // Digit enable only during the first quarter of each slot when dimmed.
  localparam logic [CW-1:0] DIM_ON = CW'(SCAN_DIV / 4);
  assign an = (dim && (r_cnt >= DIM_ON)) ? 4'b1111 : r_an;
`else
  assign an = r_an;
`endif

endmodule
